// File: rtl/operand_entry.sv
// Two-operand keypad entry for the calculator: collects X, Y (0-99) and an op code,
// then pulses calc_valid once when the second operand is confirmed.
module operand_entry (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic [6:0] x,
    output logic [6:0] y,
    output logic [1:0] op,
    output logic       led_x,
    output logic       led_y,
    output logic       calc_valid
);

    typedef enum logic [1:0] {
        ENTER_X = 2'd0,
        ENTER_Y = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0] KEY_OP    = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;
    localparam logic [3:0] KEY_CLEAR = 4'd13;

    state_t     state;
    state_t     state_nxt;
    logic       key_valid_d;
    logic       key_evt;
    logic [6:0] x_nxt;
    logic [6:0] y_nxt;
    logic [1:0] op_nxt;
    logic       cv_nxt;

    // Shift a decimal digit in, keeping only the last two digits so the result stays <= 99.
    function automatic logic [6:0] push_digit(input logic [6:0] cur, input logic [3:0] d);
        logic [6:0] ones;
        ones = cur % 7'd10;
        return (ones * 7'd10) + {3'd0, d};
    endfunction

    assign key_evt = key_valid & ~key_valid_d;
    assign led_x   = (state == ENTER_X);
    assign led_y   = (state == ENTER_Y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ENTER_X;
            x           <= 7'd0;
            y           <= 7'd0;
            op          <= 2'd0;
            calc_valid  <= 1'b0;
            // Treat the key as already held so a press spanning reset release is not counted.
            key_valid_d <= 1'b1;
        end else begin
            state       <= state_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            op          <= op_nxt;
            calc_valid  <= cv_nxt;
            key_valid_d <= key_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        op_nxt    = op;
        cv_nxt    = 1'b0;
        if (key_evt) begin
            if (key == KEY_CLEAR) begin
                state_nxt = ENTER_X;
                x_nxt     = 7'd0;
                y_nxt     = 7'd0;
                op_nxt    = 2'd0;
            end else if (key <= 4'd9) begin
                case (state)
                    ENTER_X: x_nxt = push_digit(x, key);
                    ENTER_Y: y_nxt = push_digit(y, key);
                    default: begin
                        // A digit after a completed entry starts a fresh X with the op kept.
                        state_nxt = ENTER_X;
                        x_nxt     = {3'd0, key};
                        y_nxt     = 7'd0;
                    end
                endcase
            end else if (key == KEY_OP) begin
                if (state != DONE) begin
                    op_nxt = op + 2'd1;
                end
            end else if (key == KEY_ENTER) begin
                case (state)
                    ENTER_X: begin
                        state_nxt = ENTER_Y;
                        y_nxt     = 7'd0;
                    end
                    ENTER_Y: begin
                        state_nxt = DONE;
                        cv_nxt    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: a behavioural model queues the expected outputs per
// cycle; a monitor pops and compares them, and each scenario adds its own direct checks.
module tb_operand_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic       key_valid;
    logic [6:0] x;
    logic [6:0] y;
    logic [1:0] op;
    logic       led_x;
    logic       led_y;
    logic       calc_valid;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic [1:0] op;
        logic       lx;
        logic       ly;
        logic       cv;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // model state: mst 0=ENTER_X 1=ENTER_Y 2=DONE
    int mx, my, mop, mst, mcv;

    operand_entry dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .key_valid  (key_valid),
        .x          (x),
        .y          (y),
        .op         (op),
        .led_x      (led_x),
        .led_y      (led_y),
        .calc_valid (calc_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic exp_t exp_now();
        exp_t e;
        e.x  = mx[6:0];
        e.y  = my[6:0];
        e.op = mop[1:0];
        e.lx = (mst == 0);
        e.ly = (mst == 1);
        e.cv = (mcv != 0);
        return e;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mop = 0; mst = 0; mcv = 0;
    endtask

    task automatic model_key(input int k);
        mcv = 0;
        if (k == 13) begin
            mx = 0; my = 0; mop = 0; mst = 0;
        end else if (k <= 9) begin
            if (mst == 0)      mx = (mx % 10) * 10 + k;
            else if (mst == 1) my = (my % 10) * 10 + k;
            else begin
                mst = 0; mx = k; my = 0;
            end
        end else if (k == 10) begin
            if (mst != 2) mop = (mop + 1) % 4;
        end else if (k == 11) begin
            if (mst == 0) begin
                mst = 1; my = 0;
            end else if (mst == 1) begin
                mst = 2; mcv = 1;
            end
        end
    endtask

    // Monitor: one expectation pushed per negedge, popped just after the following posedge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                got = {x, y, op, led_x, led_y, calc_valid};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t got x=%0d y=%0d op=%0d lx=%b ly=%b cv=%b want x=%0d y=%0d op=%0d lx=%b ly=%b cv=%b",
                             $time, got.x, got.y, got.op, got.lx, got.ly, got.cv,
                             e.x, e.y, e.op, e.lx, e.ly, e.cv);
                end
            end
        end
    end

    task automatic press(input int k);
        @(negedge clk);
        key       = 4'(k);
        key_valid = 1'b1;
        model_key(k);
        sbq.push_back(exp_now());
        @(negedge clk);
        key_valid = 1'b0;
        mcv       = 0;
        sbq.push_back(exp_now());
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; key = 4'd0; key_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({x, y, op, led_x, led_y, calc_valid} !== {7'd0, 7'd0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got x=%0d y=%0d op=%0d lx=%b ly=%b cv=%b want 0 0 0 1 0 0",
                     x, y, op, led_x, led_y, calc_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            sbq.push_back(exp_now());
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_full_entry();
        int seq[7] = '{4, 2, 11, 10, 10, 7, 11};
        for (int i = 0; i < 7; i++) press(seq[i]);
        n_tests++;
        if ({x, y, op, led_x, led_y, calc_valid} !== {7'd42, 7'd7, 2'd2, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL full_entry got x=%0d y=%0d op=%0d lx=%b ly=%b cv=%b want 42 7 2 0 0 0",
                     x, y, op, led_x, led_y, calc_valid);
        end
        // Enter, op and ignored codes while DONE change nothing.
        press(11);
        press(10);
        press(12);
        press(14);
        press(15);
        n_tests++;
        if ({x, y, op, led_x, led_y} !== {7'd42, 7'd7, 2'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL done_ignore got x=%0d y=%0d op=%0d lx=%b ly=%b want 42 7 2 0 0",
                     x, y, op, led_x, led_y);
        end
    endtask

    task automatic test_wrap();
        press(13);
        press(1); press(2); press(3);
        n_tests++;
        if (x !== 7'd23) begin
            n_fail++;
            $display("FAIL wrap_123 got x=%0d want 23", x);
        end
        press(9); press(9); press(9);
        n_tests++;
        if (x !== 7'd99) begin
            n_fail++;
            $display("FAIL wrap_999 got x=%0d want 99", x);
        end
        press(13);
        for (int i = 0; i < 5; i++) press(10);
        n_tests++;
        if (op !== 2'd1) begin
            n_fail++;
            $display("FAIL op_wrap got op=%0d want 1", op);
        end
        press(12); press(14); press(15);
        press(11);
        press(4); press(5); press(6);
        press(10);
        n_tests++;
        if ({x, y, op, led_y} !== {7'd0, 7'd56, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_y got x=%0d y=%0d op=%0d ly=%b want 0 56 2 1", x, y, op, led_y);
        end
    endtask

    task automatic test_hold();
        press(13);
        @(negedge clk);
        key       = 4'd5;
        key_valid = 1'b1;
        model_key(5);
        sbq.push_back(exp_now());
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            sbq.push_back(exp_now());
        end
        @(negedge clk);
        key_valid = 1'b0;
        sbq.push_back(exp_now());
        @(posedge clk);
        #2;
        n_tests++;
        if (x !== 7'd5) begin
            n_fail++;
            $display("FAIL hold_single got x=%0d want 5", x);
        end
        press(5);
        n_tests++;
        if (x !== 7'd55) begin
            n_fail++;
            $display("FAIL hold_repress got x=%0d want 55", x);
        end
    endtask

    task automatic test_clear();
        press(13);
        press(8); press(11); press(6); press(13);
        n_tests++;
        if ({x, y, op, led_x, led_y, calc_valid} !== {7'd0, 7'd0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear got x=%0d y=%0d op=%0d lx=%b ly=%b cv=%b want 0 0 0 1 0 0",
                     x, y, op, led_x, led_y, calc_valid);
        end
    endtask

    task automatic test_async_reset();
        press(1); press(11); press(4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({x, y, op, led_x, led_y, calc_valid} !== {7'd0, 7'd0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_y got x=%0d y=%0d op=%0d lx=%b ly=%b cv=%b want 0 0 0 1 0 0",
                     x, y, op, led_x, led_y, calc_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Reset during the calc_valid cycle must cut the pulse short.
        press(2); press(11); press(3);
        @(negedge clk);
        key = 4'd11; key_valid = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (calc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cv_before_abort got cv=%b want 1", calc_valid);
        end
        #1 rst_n = 1'b0;
        key_valid = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({x, y, op, led_x, led_y, calc_valid} !== {7'd0, 7'd0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_cv got x=%0d y=%0d op=%0d lx=%b ly=%b cv=%b want 0 0 0 1 0 0",
                     x, y, op, led_x, led_y, calc_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back(exp_now());
        @(negedge clk);
        sbq.push_back(exp_now());
        @(posedge clk);
        #2;
        press(5); press(11); press(10); press(6); press(11);
        press(3);
        n_tests++;
        if ({x, y, op, led_x, led_y} !== {7'd3, 7'd0, 2'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL done_digit got x=%0d y=%0d op=%0d lx=%b ly=%b want 3 0 1 1 0",
                     x, y, op, led_x, led_y);
        end
    endtask

    task automatic test_held_through_reset();
        press(9);
        @(negedge clk);
        key = 4'd7; key_valid = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sbq.push_back(exp_now());
        end
        @(negedge clk);
        key_valid = 1'b0;
        sbq.push_back(exp_now());
        @(posedge clk);
        #2;
        n_tests++;
        if (x !== 7'd0) begin
            n_fail++;
            $display("FAIL held_reset got x=%0d want 0", x);
        end
        press(7);
        n_tests++;
        if (x !== 7'd7) begin
            n_fail++;
            $display("FAIL held_repress got x=%0d want 7", x);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_entry();
        test_wrap();
        test_hold();
        test_clear();
        test_async_reset();
        test_held_through_reset();
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
